// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter that frames one packet per grant onto the TX FIFO:
// header (HDR_BASE | id), payload bytes, then an XOR checksum byte.
module uart_tx_scheduler #(
    parameter int                    DATA_BITS = 8,
    parameter int                    NUM_SRC   = 4,
    parameter int                    SRC_BITS  = 2,
    parameter logic [DATA_BITS-1:0]  HDR_BASE  = 8'hA0
) (
    input  logic                          clk_50MHz,
    input  logic                          reset,
    input  logic [NUM_SRC-1:0]            src_valid,
    input  logic [NUM_SRC*DATA_BITS-1:0]  src_data,
    input  logic [NUM_SRC-1:0]            src_last,
    output logic [NUM_SRC-1:0]            src_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr,
    output logic [DATA_BITS-1:0]          fifo_wdata,
    output logic                          busy,
    output logic [SRC_BITS-1:0]           grant_id,
    output logic                          pkt_done_tick
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HEADER,
        S_PAYLOAD,
        S_CHECKSUM
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [SRC_BITS-1:0]   r_grant;
    logic [SRC_BITS-1:0]   w_grant_nxt;
    logic [SRC_BITS-1:0]   r_rr;
    logic [SRC_BITS-1:0]   w_rr_nxt;
    logic [DATA_BITS-1:0]  r_chk;
    logic [DATA_BITS-1:0]  w_chk_nxt;
    logic                  r_done;
    logic                  w_done_nxt;

    logic                  w_hit;
    logic [SRC_BITS-1:0]   w_pick;
    int                    w_idx;
    logic [DATA_BITS-1:0]  w_hdr;
    logic [DATA_BITS-1:0]  w_src_byte;
    logic                  w_src_valid;
    logic                  w_src_last;

    assign w_hdr       = HDR_BASE | DATA_BITS'(r_grant);
    assign w_src_byte  = src_data[int'(r_grant)*DATA_BITS +: DATA_BITS];
    assign w_src_valid = src_valid[r_grant];
    assign w_src_last  = src_last[r_grant];

    assign busy          = (r_state != S_IDLE);
    assign grant_id      = r_grant;
    assign pkt_done_tick = r_done;

    // Search starts just after the last served source, wrapping once.
    always_comb begin
        w_hit  = 1'b0;
        w_pick = '0;
        w_idx  = 0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            w_idx = (int'(r_rr) + k) % NUM_SRC;
            if (!w_hit && src_valid[w_idx[SRC_BITS-1:0]]) begin
                w_hit  = 1'b1;
                w_pick = w_idx[SRC_BITS-1:0];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_rr_nxt    = r_rr;
        w_chk_nxt   = r_chk;
        w_done_nxt  = 1'b0;
        fifo_wr     = 1'b0;
        fifo_wdata  = '0;
        src_ready   = '0;
        unique case (r_state)
            S_IDLE: begin
                if (w_hit) begin
                    w_grant_nxt = w_pick;
                    w_chk_nxt   = HDR_BASE | DATA_BITS'(w_pick);
                    w_state_nxt = S_HEADER;
                end
            end
            S_HEADER: begin
                fifo_wdata = w_hdr;
                fifo_wr    = ~fifo_full;
                if (!fifo_full) begin
                    w_state_nxt = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                src_ready[r_grant] = ~fifo_full;
                fifo_wdata         = w_src_byte;
                fifo_wr            = w_src_valid & ~fifo_full;
                if (fifo_wr) begin
                    w_chk_nxt = r_chk ^ w_src_byte;
                    if (w_src_last) begin
                        w_state_nxt = S_CHECKSUM;
                    end
                end
            end
            S_CHECKSUM: begin
                fifo_wdata = r_chk;
                fifo_wr    = ~fifo_full;
                if (!fifo_full) begin
                    w_rr_nxt    = r_grant;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_rr    <= SRC_BITS'(NUM_SRC - 1);
            r_chk   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_rr    <= w_rr_nxt;
            r_chk   <= w_chk_nxt;
            r_done  <= w_done_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: expected FIFO bytes are queued
// per packet and popped as the DUT writes them.
module tb_uart_tx_scheduler;

    localparam int N = 4;

    typedef struct packed {
        logic [3:0] rdy;
        logic       done;
        logic       bsy;
        logic       wr;
        logic [1:0] gid;
    } tr_t;

    logic         clk_50MHz = 1'b0;
    logic         reset;
    logic [3:0]   src_valid;
    logic [31:0]  src_data;
    logic [3:0]   src_last;
    logic [3:0]   src_ready;
    logic         fifo_full;
    logic         fifo_wr;
    logic [7:0]   fifo_wdata;
    logic         busy;
    logic [1:0]   grant_id;
    logic         pkt_done_tick;

    int           total = 0;
    int           bad   = 0;
    logic [8:0]   sq [N][$];
    logic [7:0]   exp_q [$];
    tr_t          tr [$];
    logic [3:0]   gap;

    always #10 clk_50MHz = ~clk_50MHz;

    uart_tx_scheduler dut (
        .clk_50MHz     (clk_50MHz),
        .reset         (reset),
        .src_valid     (src_valid),
        .src_data      (src_data),
        .src_last      (src_last),
        .src_ready     (src_ready),
        .fifo_full     (fifo_full),
        .fifo_wr       (fifo_wr),
        .fifo_wdata    (fifo_wdata),
        .busy          (busy),
        .grant_id      (grant_id),
        .pkt_done_tick (pkt_done_tick)
    );

    // FIFO-side scoreboard
    always @(negedge clk_50MHz) begin
        if (!reset && fifo_wr === 1'b1) begin
            total++;
            if (fifo_full !== 1'b0) begin
                bad++;
                $display("FAIL wr_while_full: fifo_wr=1 fifo_full=%b", fifo_full);
            end else if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL extra_write: got %h, expected no write", fifo_wdata);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (fifo_wdata !== e) begin
                    bad++;
                    $display("FAIL fifo_byte: got %h expected %h", fifo_wdata, e);
                end
            end
        end
    end

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (sq[i].size() > 0 && !gap[i]) begin
                src_valid[i]       = 1'b1;
                src_data[i*8 +: 8] = sq[i][0][7:0];
                src_last[i]        = sq[i][0][8];
            end else begin
                src_valid[i]       = 1'b0;
                src_data[i*8 +: 8] = 8'hEE;
                src_last[i]        = 1'b1;
            end
        end
    endtask

    task automatic tick();
        tr_t t;
        @(negedge clk_50MHz);
        t = {src_ready, pkt_done_tick, busy, fifo_wr, grant_id};
        tr.push_back(t);
        for (int i = 0; i < N; i++) begin
            if (src_valid[i] && src_ready[i] && sq[i].size() > 0)
                void'(sq[i].pop_front());
        end
        @(posedge clk_50MHz);
        #1;
        drive();
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        fifo_full = 1'b0;
        gap       = '0;
        for (int i = 0; i < N; i++) sq[i].delete();
        exp_q.delete();
        drive();
        repeat (2) @(posedge clk_50MHz);
        #1;
        reset = 1'b0;
        tr.delete();
    endtask

    task automatic add_pkt(input int s, input int n,
                           input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2);
        logic [7:0] b [3];
        logic [7:0] chk;
        b   = '{b0, b1, b2};
        chk = 8'hA0 | 8'(s);
        exp_q.push_back(chk);
        for (int k = 0; k < n; k++) begin
            sq[s].push_back({(k == n - 1), b[k]});
            exp_q.push_back(b[k]);
            chk ^= b[k];
        end
        exp_q.push_back(chk);
    endtask

    task automatic check_drained(input string name);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drained: %0d bytes left, expected 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk_50MHz);
        total++;
        if ({busy, fifo_wr, src_ready} !== 6'b0) begin
            bad++;
            $display("FAIL rst_ctrl: busy=%b wr=%b rdy=%b expected 0", busy, fifo_wr, src_ready);
        end
        total++;
        if (grant_id !== 2'd0 || fifo_wdata !== 8'h00) begin
            bad++;
            $display("FAIL rst_data: gid=%0d wdata=%h expected 0/00", grant_id, fifo_wdata);
        end
        total++;
        if (pkt_done_tick !== 1'b0) begin
            bad++;
            $display("FAIL rst_tick: got %b expected 0", pkt_done_tick);
        end
        @(posedge clk_50MHz);
        #1;
    endtask

    task automatic test_single();
        int nd;
        do_reset();
        add_pkt(1, 2, 8'h11, 8'h22, 8'h00);
        drive();
        repeat (9) tick();
        check_drained("single");
        nd = 0;
        foreach (tr[i]) if (tr[i].done) nd++;
        total++;
        if (nd != 1 || tr[5].done !== 1'b1) begin
            bad++;
            $display("FAIL single_tick: pulses=%0d at5=%b expected 1/1", nd, tr[5].done);
        end
        total++;
        if (tr[0].wr !== 1'b0 || tr[4].wr !== 1'b1 || tr[5].wr !== 1'b0) begin
            bad++;
            $display("FAIL single_timing: wr0=%b wr4=%b wr5=%b expected 0/1/0",
                     tr[0].wr, tr[4].wr, tr[5].wr);
        end
    endtask

    task automatic test_two();
        do_reset();
        add_pkt(0, 1, 8'h05, 8'h00, 8'h00);
        add_pkt(2, 1, 8'h07, 8'h00, 8'h00);
        drive();
        repeat (12) tick();
        check_drained("two");
        total++;
        if (tr[1].gid !== 2'd0 || tr[5].gid !== 2'd2) begin
            bad++;
            $display("FAIL two_grant: g1=%0d g5=%0d expected 0/2", tr[1].gid, tr[5].gid);
        end
        total++;
        if (tr[4].bsy !== 1'b0 || tr[4].wr !== 1'b0 || tr[5].bsy !== 1'b1) begin
            bad++;
            $display("FAIL two_idle_gap: busy4=%b wr4=%b busy5=%b expected 0/0/1",
                     tr[4].bsy, tr[4].wr, tr[5].bsy);
        end
    endtask

    task automatic test_rr();
        int nd;
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < N; s++)
                add_pkt(s, 1, 8'(16 * s + r + 1), 8'h00, 8'h00);
        drive();
        repeat (40) tick();
        check_drained("rr");
        nd = 0;
        foreach (tr[i]) if (tr[i].done) nd++;
        total++;
        if (nd != 8) begin
            bad++;
            $display("FAIL rr_pkts: got %0d expected 8", nd);
        end
    endtask

    task automatic test_stall();
        do_reset();
        add_pkt(3, 3, 8'h10, 8'h20, 8'h30);
        drive();
        for (int k = 0; k < 14; k++) begin
            fifo_full = (k >= 3 && k <= 5);
            tick();
        end
        fifo_full = 1'b0;
        check_drained("stall");
        for (int k = 3; k <= 5; k++) begin
            total++;
            if (tr[k].wr !== 1'b0 || tr[k].rdy !== 4'b0) begin
                bad++;
                $display("FAIL stall_hold%0d: wr=%b rdy=%b expected 0/0", k, tr[k].wr, tr[k].rdy);
            end
        end
        total++;
        if (tr[6].wr !== 1'b1 || tr[6].rdy !== 4'b1000) begin
            bad++;
            $display("FAIL stall_resume: wr=%b rdy=%b expected 1/1000", tr[6].wr, tr[6].rdy);
        end
    endtask

    task automatic test_gap();
        do_reset();
        add_pkt(0, 3, 8'h01, 8'h02, 8'h03);
        drive();
        for (int k = 0; k < 12; k++) begin
            gap[0] = (k == 3 || k == 4);
            drive();
            tick();
        end
        gap = '0;
        check_drained("gap");
        for (int k = 3; k <= 4; k++) begin
            total++;
            if (tr[k].bsy !== 1'b1 || tr[k].wr !== 1'b0) begin
                bad++;
                $display("FAIL gap_hold%0d: busy=%b wr=%b expected 1/0", k, tr[k].bsy, tr[k].wr);
            end
        end
    endtask

    task automatic test_reset_mid();
        tr_t t;
        do_reset();
        sq[2].push_back({1'b0, 8'h55});
        sq[2].push_back({1'b0, 8'h66});
        sq[2].push_back({1'b1, 8'h77});
        exp_q.push_back(8'hA2);
        exp_q.push_back(8'h55);
        drive();
        repeat (3) tick();
        gap[2] = 1'b1;
        drive();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        gap   = '0;
        sq[2].delete();
        add_pkt(1, 1, 8'h3C, 8'h00, 8'h00);
        drive();
        tick();
        t = tr[tr.size() - 1];
        total++;
        if (t.bsy !== 1'b0 || t.wr !== 1'b0 || t.rdy !== 4'b0 || t.gid !== 2'd0) begin
            bad++;
            $display("FAIL mid_reset: busy=%b wr=%b rdy=%b gid=%0d expected 0/0/0000/0",
                     t.bsy, t.wr, t.rdy, t.gid);
        end
        repeat (8) tick();
        check_drained("mid_reset");
    endtask

    initial begin
        reset     = 1'b1;
        fifo_full = 1'b0;
        gap       = '0;
        src_valid = '0;
        src_data  = '0;
        src_last  = '0;
        test_reset();
        test_single();
        test_two();
        test_rr();
        test_stall();
        test_gap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
